rc4_keystream: RTL and testbench

- RC4 keystream generator that sits directly upstream of the per-channel encrypt/decrypt XOR stages in the audio link.
- Runs key scheduling (KSA) once per start, then emits one 24-bit keystream word per codec sample request.
- Three RC4 bytes (PRGA) make up each word.
- The transmit (encrypt) and receive (decrypt) sides each instantiate one copy per channel with the same key, so their keystreams stay in lockstep.

---
 rtl/rc4_pkg.sv | 6 +
 rtl/rc4_sbox.sv | 28 ++
 rtl/rc4_keystream.sv | 160 ++++++++++++++++
 tb/tb_rc4_keystream.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: types and constants shared by the RC4 keystream generator and its S-box.
package rc4_pkg;
    localparam int SBOX_SIZE = 256;
    typedef logic [7:0] byte_t;
    typedef enum logic [3:0] {IDLE, FILL, KSA_A, KSA_B, READY, PRG_A, PRG_B, PRG_C, OUT} state_t;
endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256x8 RC4 state array with two combinational read ports and a two-entry write port.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t addr_a,
    input  byte_t addr_b,
    output byte_t rdata_a,
    output byte_t rdata_b,
    input  logic  we,
    input  byte_t waddr_a,
    input  byte_t wdata_a,
    input  byte_t waddr_b,
    input  byte_t wdata_b
);
    byte_t mem [SBOX_SIZE];

    // Both entries of a swap land on the same edge; equal addresses carry equal data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr_a] <= wdata_a;
            mem[waddr_b] <= wdata_b;
        end
    end

    assign rdata_a = mem[addr_a];
    assign rdata_b = mem[addr_b];
endmodule

// File: rtl/rc4_keystream.sv
// rc4_keystream: RC4 key scheduling once per start, then one WORD_BYTES-byte keystream word per request.
module rc4_keystream
    import rc4_pkg::*;
#(
    parameter int WORD_BYTES = 3,
    parameter int KEY_BYTES  = 3
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [8*KEY_BYTES-1:0]  key,
    input  logic                    start,
    output logic                    init_done,
    input  logic                    ks_req,
    output logic                    ks_valid,
    output logic [8*WORD_BYTES-1:0] ks_word,
    output logic                    overrun
);
    localparam int KW = 8 * KEY_BYTES;
    localparam int WW = 8 * WORD_BYTES;
    localparam int BW = $clog2(WORD_BYTES + 1);
    localparam logic [BW-1:0] LAST = BW'(WORD_BYTES - 1);

    state_t        state, state_d;
    byte_t         i, i_d, j, j_d, t, t_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic [KW-1:0] key_q, key_d;
    logic [WW-1:0] stage, stage_d, word_d;
    logic          pending, pend_d, ovr_d, done_d, valid_d;
    byte_t         ra, rb, rda, rdb, wb, wda, wdb;
    logic          we, fill;

    // PRG_B reads S[j + S[i]] in the same cycle it swaps; PRG_C reads S[S[i]+S[j]] via the saved sum.
    assign fill = state == FILL;
    assign ra   = (state == PRG_C) ? t : i;
    assign rb   = (state == PRG_B) ? j + rda : j;
    assign we   = state inside {FILL, KSA_B, PRG_B};
    assign wb   = fill ? i : rb;
    assign wda  = fill ? i : rdb;
    assign wdb  = fill ? i : rda;

    rc4_sbox u_sbox (
        .clk    (CLOCK_50),
        .addr_a (ra),
        .addr_b (rb),
        .rdata_a(rda),
        .rdata_b(rdb),
        .we     (we),
        .waddr_a(i),
        .wdata_a(wda),
        .waddr_b(wb),
        .wdata_b(wdb)
    );

    always_comb begin
        state_d = state;
        i_d     = i;
        j_d     = j;
        t_d     = t;
        bcnt_d  = bcnt;
        key_d   = key_q;
        stage_d = stage;
        word_d  = ks_word;
        pend_d  = pending;
        ovr_d   = overrun;
        done_d  = init_done;
        valid_d = 1'b0;
        if (ks_req && state inside {PRG_A, PRG_B, PRG_C}) {pend_d, ovr_d} = {1'b1, overrun | pending};
        else if (ks_req && state inside {IDLE, FILL, KSA_A, KSA_B}) ovr_d = 1'b1;
        case (state)
            FILL: begin
                i_d = i + 8'd1;
                if (i == 8'hFF) begin
                    state_d = KSA_A;
                    j_d     = '0;
                end
            end
            KSA_A: begin
                j_d     = j + rda + key_q[KW-1 -: 8];
                state_d = KSA_B;
            end
            // The key register rotates so its top byte is always key[i mod KEY_BYTES].
            KSA_B: begin
                i_d     = i + 8'd1;
                key_d   = (key_q << 8) | (key_q >> (KW - 8));
                state_d = (i == 8'hFF) ? READY : KSA_A;
                j_d     = (i == 8'hFF) ? '0 : j;
            end
            READY: begin
                done_d = 1'b1;
                if (ks_req) begin
                    state_d = PRG_A;
                    bcnt_d  = '0;
                end
            end
            PRG_A: begin
                i_d     = i + 8'd1;
                state_d = PRG_B;
            end
            PRG_B: begin
                j_d     = rb;
                t_d     = rda + rdb;
                state_d = PRG_C;
            end
            PRG_C: begin
                stage_d = (stage << 8) | WW'(rda);
                bcnt_d  = bcnt + 1'b1;
                state_d = (bcnt == LAST) ? OUT : PRG_A;
            end
            OUT: begin
                word_d  = stage;
                valid_d = 1'b1;
                state_d = (pending || ks_req) ? PRG_A : READY;
                bcnt_d  = '0;
                pend_d  = pending && ks_req;
            end
            default: ;
        endcase
        if (start) begin
            state_d = FILL;
            i_d     = '0;
            j_d     = '0;
            key_d   = key;
            pend_d  = 1'b0;
            ovr_d   = 1'b0;
            done_d  = 1'b0;
            word_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            t         <= '0;
            bcnt      <= '0;
            key_q     <= '0;
            stage     <= '0;
            ks_word   <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            init_done <= 1'b0;
            ks_valid  <= 1'b0;
        end else begin
            state     <= state_d;
            i         <= i_d;
            j         <= j_d;
            t         <= t_d;
            bcnt      <= bcnt_d;
            key_q     <= key_d;
            stage     <= stage_d;
            ks_word   <= word_d;
            pending   <= pend_d;
            overrun   <= ovr_d;
            init_done <= done_d;
            ks_valid  <= valid_d;
        end
    end
endmodule

// File: tb/tb_rc4_keystream.sv
// tb_rc4_keystream: directed checks of an encrypt/decrypt pair against an array-based RC4 model.
module tb_rc4_keystream;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ks_req = 1'b0;
    logic [23:0] key = '0;
    logic        tx_done, rx_done, tx_valid, rx_valid, tx_ovr, rx_ovr;
    logic [23:0] tx_word, rx_word;
    int          checks = 0, failures = 0, cyc = 0, vcount = 0;
    logic [7:0]  ms [256];
    int          mi = 0, mj = 0;
    logic [23:0] cw, cs;
    logic [23:0] kat_w [3] = '{24'hEB9F77, 24'h81B734, 24'hCA72A7};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc4_keystream #(.WORD_BYTES(3), .KEY_BYTES(3)) dut_tx (
        .CLOCK_50(clk), .reset_n(rst_n), .key(key), .start(start), .init_done(tx_done),
        .ks_req(ks_req), .ks_valid(tx_valid), .ks_word(tx_word), .overrun(tx_ovr)
    );
    rc4_keystream #(.WORD_BYTES(3), .KEY_BYTES(3)) dut_rx (
        .CLOCK_50(clk), .reset_n(rst_n), .key(key), .start(start), .init_done(rx_done),
        .ks_req(ks_req), .ks_valid(rx_valid), .ks_word(rx_word), .overrun(rx_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_init(input logic [23:0] k);
        logic [7:0] tmp;
        int jj = 0;
        for (int x = 0; x < 256; x++) ms[x] = 8'(x);
        for (int x = 0; x < 256; x++) begin
            jj = (jj + ms[x] + k[8*(2 - x % 3) +: 8]) % 256;
            tmp = ms[x]; ms[x] = ms[jj]; ms[jj] = tmp;
        end
        mi = 0;
        mj = 0;
    endtask

    task automatic model_word(output logic [23:0] w);
        logic [7:0] tmp;
        w = '0;
        for (int b = 0; b < 3; b++) begin
            mi = (mi + 1) % 256;
            mj = (mj + ms[mi]) % 256;
            tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
            w = {w[15:0], ms[(ms[mi] + ms[mj]) % 256]};
        end
    endtask

    // Every emitted word must match the model, the partner instance, and undo its own XOR.
    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            vcount++;
            model_word(cw);
            cs = 24'($urandom);
            chk("model_word", tx_word, cw);
            chk("pair_valid", rx_valid, 1);
            chk("pair_word", rx_word, tx_word);
            chk("xor_roundtrip", cs ^ tx_word ^ rx_word, cs);
        end
    end

    task automatic pulse_start(input logic [23:0] k, output int n);
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = cyc;
        model_init(k);
    endtask

    task automatic pulse_req();
        ks_req = 1'b1;
        @(negedge clk);
        ks_req = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!tx_done && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("init_done_timeout", tx_done, 1);
    endtask

    task automatic kat(input string name);
        for (int w = 0; w < 3; w++) begin
            pulse_req();
            repeat (19) @(negedge clk);
            chk(name, tx_word, kat_w[w]);
        end
    endtask

    task automatic req_wait();
        int k = 0;
        pulse_req();
        while (!tx_valid && k < 15) begin
            @(negedge clk);
            k++;
        end
        chk("word_timeout", tx_valid, 1);
    endtask

    initial begin
        int n, v0;
        logic [23:0] w;
        model_init(24'h4B6579);
        model_word(w);
        chk("model_pin0", w, 24'hEB9F77);
        model_word(w);
        chk("model_pin1", w, 24'h81B734);

        repeat (2) @(negedge clk);
        chk("rst_init_done", tx_done, 0);
        chk("rst_ks_valid", tx_valid, 0);
        chk("rst_ks_word", tx_word, 0);
        chk("rst_overrun", tx_ovr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pulse_start(24'h4B6579, n);
        while (cyc < n + 199) @(negedge clk);
        pulse_req();
        chk("init_drop_overrun", tx_ovr, 1);
        while (cyc < n + 768) @(negedge clk);
        chk("init_done_low_768", tx_done, 0);
        @(negedge clk);
        chk("init_done_high_769", tx_done, 1);
        kat("kat_first");
        chk("overrun_sticky", tx_ovr, 1);

        pulse_req();
        repeat (2) @(negedge clk);
        v0 = vcount;
        pulse_start(24'h4B6579, n);
        chk("restart_overrun_clr", tx_ovr, 0);
        chk("restart_word_clr", tx_word, 0);
        chk("restart_done_clr", tx_done, 0);
        repeat (20) @(negedge clk);
        chk("restart_no_valid", vcount, v0);
        wait_done();
        kat("kat_restart");

        for (int d = 0; d <= 20; d++) begin
            ks_req = (d == 0 || d == 3 || d == 5);
            @(negedge clk);
            ks_req = 1'b0;
            if (d == 9 || d == 19) chk("lat_valid_early", tx_valid, 0);
            if (d == 10 || d == 20) chk("lat_valid_on_time", tx_valid, 1);
            if (d == 4) chk("pending_no_overrun", tx_ovr, 0);
            if (d == 5) chk("double_pending_overrun", tx_ovr, 1);
        end
        repeat (5) @(negedge clk);

        pulse_start(24'h4B6579, n);
        while (cyc < n + 300) @(negedge clk);
        pulse_req();
        chk("ksa_drop_overrun", tx_ovr, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_overrun", tx_ovr, 0);
        chk("async_ks_valid", tx_valid, 0);
        chk("async_ks_word", tx_word, 0);
        chk("async_init_done", tx_done, 0);
        #4 rst_n = 1'b1;
        repeat (800) @(negedge clk);
        chk("idle_after_reset", tx_done, 0);
        pulse_start(24'h4B6579, n);
        wait_done();
        kat("kat_after_reset");

        for (int k = 0; k < 1000; k++) req_wait();
        chk("pair_overrun", rx_ovr, tx_ovr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
